sram_1rw1r_param: RTL

Synthesizable, parametrised successor of the fixed 32x256 1RW1R SRAM model, used as the fabric BRAM primitive.
- Port 0 is read/write with lane write mask; port 1 is read-only.
- Single clock with registered read outputs and read-valid strobes.
- Clears the whole array after every reset.
- Detects port-0-write / port-1-read address collisions; read-during-write forwarding is optional.

---
 rtl/sram_1rw1r_param_if.sv | 29 ++
 rtl/sram_1rw1r_param.sv | 71 +++++++
 2 files changed

// File: rtl/sram_1rw1r_param_if.sv
// sram_1rw1r_param_if: port bundle for the 1RW1R SRAM (port 0 read/write, port 1 read-only)
interface sram_1rw1r_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int LANE_WIDTH = 8
);
  localparam int NUM_WMASKS = DATA_WIDTH / LANE_WIDTH;
  logic                  csb0;
  logic                  web0;
  logic [NUM_WMASKS-1:0] wmask0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] dout0;
  logic                  dout0_valid;
  logic                  csb1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] dout1;
  logic                  dout1_valid;
  logic                  init_busy;
  logic                  collision;
  modport master (
    output csb0, web0, wmask0, addr0, din0, csb1, addr1,
    input  dout0, dout0_valid, dout1, dout1_valid, init_busy, collision
  );
  modport slave (
    input  csb0, web0, wmask0, addr0, din0, csb1, addr1,
    output dout0, dout0_valid, dout1, dout1_valid, init_busy, collision
  );
endinterface

// File: rtl/sram_1rw1r_param.sv
// sram_1rw1r_param: parametrised 1RW1R SRAM, array cleared after every reset, collision detect.
// Optional macro SRAM_RW_BYPASS_EN: port 1 returns the post-write word on a collision.
module sram_1rw1r_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int LANE_WIDTH = 8
) (
  input logic               clk0,
  input logic               rst_n,
  sram_1rw1r_param_if.slave bus
);
  localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;
  localparam int NUM_WMASKS = DATA_WIDTH / LANE_WIDTH;
  if (DATA_WIDTH % LANE_WIDTH != 0) begin : g_bad_lane
    $error("DATA_WIDTH must be a multiple of LANE_WIDTH");
  end
  typedef enum logic {INIT, READY} state_t;
  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
  logic                  w_ready, w_wr, w_rd0, w_rd1, w_coll;
  logic [DATA_WIDTH-1:0] w_wr_word, w_dout1;
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (r_state == INIT) ? r_cnt + 1'b1 : '0;
    end
  end
  always_comb begin
    w_state_nxt = (r_state == INIT && r_cnt == {ADDR_WIDTH{1'b1}}) ? READY : r_state;
  end
  assign w_ready = r_state == READY;
  assign w_wr    = w_ready & ~bus.csb0 & ~bus.web0;
  assign w_rd0   = w_ready & ~bus.csb0 & bus.web0;
  assign w_rd1   = w_ready & ~bus.csb1;
  assign w_coll  = w_wr & (|bus.wmask0) & w_rd1 & (bus.addr0 == bus.addr1);
  // Merged post-write word; also the bypass value when port 1 hits the same address
  always_comb begin
    w_wr_word = r_mem[bus.addr0];
    for (int i = 0; i < NUM_WMASKS; i++)
      if (bus.wmask0[i]) w_wr_word[i*LANE_WIDTH +: LANE_WIDTH] = bus.din0[i*LANE_WIDTH +: LANE_WIDTH];
  end
`ifdef SRAM_RW_BYPASS_EN
  assign w_dout1 = w_coll ? w_wr_word : r_mem[bus.addr1];
`else
  assign w_dout1 = r_mem[bus.addr1];
`endif
  always_ff @(posedge clk0) begin
    if (r_state == INIT) r_mem[r_cnt] <= '0;
    else if (w_wr) r_mem[bus.addr0] <= w_wr_word;
  end
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      bus.dout0       <= '0;
      bus.dout1       <= '0;
      bus.dout0_valid <= 1'b0;
      bus.dout1_valid <= 1'b0;
      bus.collision   <= 1'b0;
    end else begin
      bus.dout0       <= w_rd0 ? r_mem[bus.addr0] : bus.dout0;
      bus.dout1       <= w_rd1 ? w_dout1 : bus.dout1;
      bus.dout0_valid <= w_rd0;
      bus.dout1_valid <= w_rd1;
      bus.collision   <= w_coll;
    end
  end
  assign bus.init_busy = r_state == INIT;
endmodule
